digi2hex_6bit: RTL and testbench

DIGI2HEX_6BIT -- requirements
Module: digi2hex_6bit

---
 rtl/digi2hex_6bit.sv | 84 ++++++++
 tb/tb_digi2hex_6bit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/digi2hex_6bit.sv
// digi2hex_6bit: decodes a two-digit 7-segment display (00..63) into a 6-bit value
// through a two-stage valid/ready pipeline, flagging illegal displays and counting errors.
module digi2hex_6bit (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] digi_1,
    input  logic [6:0] digi_0,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] hex,
    output logic       err,
    output logic [7:0] err_cnt
);
    // {illegal, bcd}; blank decodes as a legal 0 here and each digit position adds its own rules
    function automatic logic [4:0] seg_dec(input logic [6:0] s);
        case (s)
            7'b0111111: seg_dec = 5'd0;
            7'b0011000: seg_dec = 5'd1;
            7'b1110110: seg_dec = 5'd2;
            7'b1111100: seg_dec = 5'd3;
            7'b1011001: seg_dec = 5'd4;
            7'b1101101: seg_dec = 5'd5;
            7'b1101111: seg_dec = 5'd6;
            7'b0111000: seg_dec = 5'd7;
            7'b1111111: seg_dec = 5'd8;
            7'b1111101: seg_dec = 5'd9;
            7'b0000000: seg_dec = 5'd0;
            default:    seg_dec = 5'b10000;
        endcase
    endfunction
    logic [4:0] t_dec;
    logic [4:0] o_dec;
    logic       t_bad;
    logic       o_bad;
    logic       s1_valid;
    logic [3:0] s1_t;
    logic [3:0] s1_o;
    logic       s1_bad;
    logic [6:0] sum;
    logic       rng_bad;
    logic       s1_advance;
    always_comb begin
        t_dec = seg_dec(digi_1);
        o_dec = seg_dec(digi_0);
        t_bad = t_dec[4] | (t_dec[3:0] > 4'd6);
        o_bad = o_dec[4] | (digi_0 == 7'd0);
        sum = {3'd0, s1_t} * 7'd10 + {3'd0, s1_o};
        rng_bad = s1_bad | (sum > 7'd63);
        s1_advance = ~out_valid | out_ready;
        in_ready = rst_n & (~s1_valid | s1_advance);
    end
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_t <= 4'd0;
            s1_o <= 4'd0;
            s1_bad <= 1'b0;
            out_valid <= 1'b0;
            hex <= 6'd0;
            err <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_t <= t_dec[3:0];
                    s1_o <= o_dec[3:0];
                    s1_bad <= t_bad | o_bad;
                end
            end
            if (s1_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    hex <= rng_bad ? 6'd0 : sum[5:0];
                    err <= rng_bad;
                end
            end
            if (out_valid && out_ready && err && err_cnt != 8'hff)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_digi2hex_6bit.sv
// tb_digi2hex_6bit: directed stimulus with a scoreboard of expected {err,hex} results
// and an independent digit-index reference model.
module tb_digi2hex_6bit;
    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] digi_1 = 7'd0;
    logic [6:0] digi_0 = 7'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] hex;
    logic       err;
    logic [7:0] err_cnt;
    int checks = 0;
    int failures = 0;
    int delivered = 0;
    int mcnt = 0;
    logic accepted;
    logic held = 1'b0;
    logic [6:0] last_out;
    logic [6:0] sb[$];

    digi2hex_6bit dut (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .digi_1(digi_1), .digi_0(digi_0), .out_valid(out_valid), .out_ready(out_ready),
        .hex(hex), .err(err), .err_cnt(err_cnt)
    );

    always #5 clock = ~clock;

    // index 0..9 digit, 10 blank, 11 a code outside the table
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b0111111;
            1: seg = 7'b0011000;
            2: seg = 7'b1110110;
            3: seg = 7'b1111100;
            4: seg = 7'b1011001;
            5: seg = 7'b1101101;
            6: seg = 7'b1101111;
            7: seg = 7'b0111000;
            8: seg = 7'b1111111;
            9: seg = 7'b1111101;
            10: seg = 7'b0000000;
            default: seg = 7'b1010101;
        endcase
    endfunction

    function automatic logic [6:0] model(input int t, input int o);
        int tv;
        int s;
        logic e;
        tv = (t == 10) ? 0 : t;
        e = (t >= 7 && t != 10) || (o >= 10);
        s = tv * 10 + o;
        if (s > 63) e = 1'b1;
        model = e ? 7'h40 : {1'b0, s[5:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input int t, input int o, input logic rdy);
        logic [6:0] e;
        @(negedge clock);
        rst_n = r;
        in_valid = v;
        digi_1 = seg(t);
        digi_0 = seg(o);
        out_ready = rdy;
        #1;
        accepted = 1'b0;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                chk("sb_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("hex", hex, e[5:0]);
                    chk("err", err, e[6]);
                    if (e[6] && mcnt != 255) mcnt++;
                    delivered++;
                end
            end
            if (out_valid && !out_ready && held) chk("hold", {err, hex}, last_out);
            held = out_valid && !out_ready;
            last_out = {err, hex};
            if (in_valid && in_ready) begin
                sb.push_back(model(t, o));
                accepted = 1'b1;
            end
        end else
            held = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        int i;
        int n;
        int d0;
        logic dropped;
        step(1'b0, 1'b1, 3, 3, 1'b1);
        step(1'b0, 1'b1, 3, 3, 1'b1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hex", hex, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        chk("release_in_ready", in_ready, 1);
        // single decode latency
        step(1'b1, 1'b1, 6, 3, 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        chk("lat1_out_valid", out_valid, 0);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        chk("lat2_out_valid", out_valid, 1);
        chk("lat2_hex", hex, 63);
        // range and illegal codes
        step(1'b1, 1'b1, 6, 5, 1'b1);
        drain(3);
        chk("err_cnt_one", err_cnt, 1);
        step(1'b1, 1'b1, 1, 10, 1'b1);
        step(1'b1, 1'b1, 10, 7, 1'b1);
        step(1'b1, 1'b1, 11, 3, 1'b1);
        step(1'b1, 1'b1, 8, 1, 1'b1);
        step(1'b1, 1'b1, 2, 11, 1'b1);
        step(1'b1, 1'b0, 9, 9, 1'b1);
        drain(3);
        chk("err_cnt_codes", err_cnt, mcnt);
        // exhaustive back-to-back sweep
        d0 = delivered;
        for (int k = 0; k < 64; k++) begin
            step(1'b1, 1'b1, k / 10, k % 10, 1'b1);
            chk("sweep_in_ready", in_ready, 1);
        end
        drain(3);
        chk("sweep_count", delivered - d0, 64);
        // backpressure
        d0 = delivered;
        i = 0;
        n = 0;
        dropped = 1'b0;
        while (i < 10 && n < 100) begin
            step(1'b1, 1'b1, i % 6, (i + 3) % 10, n >= 5);
            if (accepted) i++;
            if (!in_ready) dropped = 1'b1;
            n++;
        end
        chk("bp_dropped", dropped, 1);
        chk("bp_accepted", i, 10);
        drain(4);
        chk("bp_delivered", delivered - d0, 10);
        chk("bp_sb_empty", sb.size(), 0);
        // reset with both stages full
        step(1'b1, 1'b1, 8, 1, 1'b0);
        step(1'b1, 1'b1, 7, 2, 1'b0);
        step(1'b1, 1'b1, 9, 3, 1'b0);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        chk("pre_rst_cnt", err_cnt, mcnt);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        sb.delete();
        mcnt = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 0, 0, 1'b1);
            chk("no_stale", out_valid, 0);
        end
        // err_cnt saturation
        for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 9, 0, 1'b1);
        drain(3);
        chk("sat_255", err_cnt, 255);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 4, 10, 1'b1);
        drain(3);
        chk("sat_hold", err_cnt, 255);
        chk("sat_model", mcnt, 255);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
